// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island constants: channel mode encodings, period lengths and
// the pixel budgets needed before an island or a further packet may start.
package hdmi_pkg;

    localparam logic [2:0] MODE_CONTROL     = 3'd0;
    localparam logic [2:0] MODE_DATA_ISLAND = 3'd3;
    localparam logic [2:0] MODE_GUARD       = 3'd4;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;
    localparam int unsigned PACKET_LEN   = 32;
    localparam int unsigned GAP_LEN      = 4;

    // Pixels needed for preamble + guards + one packet, and for one more packet + trail guard.
    localparam logic [11:0] ISLAND_START_MIN = 12'd48;
    localparam logic [11:0] PACKET_NEXT_MIN  = 12'd38;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StLeadGuard,
        StPacket,
        StTrailGuard,
        StGap
    } sched_state_e;

endpackage

// File: rtl/packet_scheduler_if.sv
// Requester/blanking inputs and island timing outputs of the packet scheduler.
interface packet_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic               blanking;
    logic [11:0]        cycles_left;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               packet_start;
    logic [4:0]         word_index;
    logic [2:0]         mode;
    logic               preamble;
    logic               overrun;

    modport master (
        output blanking, cycles_left, req,
        input  grant, packet_start, word_index, mode, preamble, overrun
    );

    modport slave (
        input  blanking, cycles_left, req,
        output grant, packet_start, word_index, mode, preamble, overrun
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after the pointer,
// wrapping around; returns the winner one-hot and as an index.
module round_robin_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic             found;
    int unsigned      idx;
    logic [PTR_W-1:0] idx_w;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        idx_w      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = int'(pointer) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PTR_W'(idx);
            if (!found && req[idx_w]) begin
                found         = 1'b1;
                winner[idx_w] = 1'b1;
                winner_idx    = idx_w;
            end
        end
    end
endmodule

// File: rtl/packet_scheduler.sv
// Data-island scheduler: sequences preamble, guards, back-to-back 32-pixel packets
// and the trailing gap inside blanking, granting requesters round-robin.
module packet_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_PACKETS = 18
) (
    input logic               clk_pixel,
    input logic               reset_n,
    packet_scheduler_if.slave bus
);
    import hdmi_pkg::*;

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam logic [4:0]  PKT_CAP = 5'(MAX_PACKETS);

    sched_state_e       state;
    logic [2:0]         phase_cnt;
    logic [4:0]         packets_sent;
    logic [PTR_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] grant_q;
    logic               packet_start_q;
    logic [4:0]         word_index_q;
    logic [2:0]         mode_q;
    logic               preamble_q;
    logic               overrun_q;

    logic [NUM_REQ-1:0] winner;
    logic [PTR_W-1:0]   winner_idx;
    logic               any_req;
    logic               start_ok;
    logic               abort;
    logic               launch;

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (bus.req),
        .pointer    (rr_ptr),
        .winner     (winner),
        .winner_idx (winner_idx)
    );

    always_comb begin
        any_req  = |bus.req;
        start_ok = bus.blanking && any_req && (bus.cycles_left >= ISLAND_START_MIN);
        abort    = (state != StIdle) && (state != StGap) && !bus.blanking;
        launch   = 1'b0;
        if (state == StLeadGuard && phase_cnt == 3'(GUARD_LEN - 1)) begin
            launch = any_req;
        end
        // A new packet only follows if the cap and the pixel budget both allow it.
        if (state == StPacket && word_index_q == 5'(PACKET_LEN - 1)) begin
            launch = any_req && (packets_sent < PKT_CAP) &&
                     (bus.cycles_left >= PACKET_NEXT_MIN);
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StIdle;
            phase_cnt      <= '0;
            packets_sent   <= '0;
            rr_ptr         <= '0;
            grant_q        <= '0;
            packet_start_q <= 1'b0;
            word_index_q   <= '0;
            mode_q         <= MODE_CONTROL;
            preamble_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            packet_start_q <= 1'b0;
            overrun_q      <= 1'b0;
            if (abort) begin
                state        <= StIdle;
                phase_cnt    <= '0;
                grant_q      <= '0;
                word_index_q <= '0;
                mode_q       <= MODE_CONTROL;
                preamble_q   <= 1'b0;
                overrun_q    <= 1'b1;
            end else if (launch) begin
                state          <= StPacket;
                phase_cnt      <= '0;
                grant_q        <= winner;
                packet_start_q <= 1'b1;
                word_index_q   <= '0;
                mode_q         <= MODE_DATA_ISLAND;
                rr_ptr         <= (winner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : winner_idx + 1'b1;
                if (packets_sent < PKT_CAP) begin
                    packets_sent <= packets_sent + 5'd1;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        packets_sent <= '0;
                        phase_cnt    <= '0;
                        if (start_ok) begin
                            state      <= StPreamble;
                            preamble_q <= 1'b1;
                        end
                    end
                    StPreamble: begin
                        if (phase_cnt == 3'(PREAMBLE_LEN - 1)) begin
                            state      <= StLeadGuard;
                            preamble_q <= 1'b0;
                            mode_q     <= MODE_GUARD;
                            phase_cnt  <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 3'd1;
                        end
                    end
                    StLeadGuard: begin
                        // Requests vanished during the preamble: close the island empty.
                        if (phase_cnt == 3'(GUARD_LEN - 1)) begin
                            state     <= StTrailGuard;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 3'd1;
                        end
                    end
                    StPacket: begin
                        if (word_index_q == 5'(PACKET_LEN - 1)) begin
                            state        <= StTrailGuard;
                            grant_q      <= '0;
                            word_index_q <= '0;
                            mode_q       <= MODE_GUARD;
                            phase_cnt    <= '0;
                        end else begin
                            word_index_q <= word_index_q + 5'd1;
                        end
                    end
                    StTrailGuard: begin
                        if (phase_cnt == 3'(GUARD_LEN - 1)) begin
                            state     <= StGap;
                            mode_q    <= MODE_CONTROL;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 3'd1;
                        end
                    end
                    StGap: begin
                        if (phase_cnt == 3'(GAP_LEN - 1)) begin
                            state     <= StIdle;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 3'd1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.packet_start = packet_start_q;
    assign bus.word_index   = word_index_q;
    assign bus.mode         = mode_q;
    assign bus.preamble     = preamble_q;
    assign bus.overrun      = overrun_q;
endmodule
